// File: rtl/saturn_bus_pkg.sv
// Shared definitions for the Saturn nibble-bus sequencer: state encoding,
// program-entry layout and the bus command codes.
package saturn_bus_pkg;

  localparam int ENTRY_W = 5;
  localparam int CMD_BIT = 4;
  localparam int IDLE_ADDR = 31;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_READ  = 2'd2,
    S_ERROR = 2'd3
  } bus_state_e;

  localparam logic [3:0] BUSCMD_PC_READ     = 4'h0;
  localparam logic [3:0] BUSCMD_DP_READ     = 4'h1;
  localparam logic [3:0] BUSCMD_PC_WRITE    = 4'h2;
  localparam logic [3:0] BUSCMD_DP_WRITE    = 4'h3;
  localparam logic [3:0] BUSCMD_LOAD_PC     = 4'h4;
  localparam logic [3:0] BUSCMD_LOAD_DP     = 4'h5;
  localparam logic [3:0] BUSCMD_CONFIGURE   = 4'h6;
  localparam logic [3:0] BUSCMD_UNCONFIGURE = 4'h7;
  localparam logic [3:0] BUSCMD_POLL        = 4'h8;
  localparam logic [3:0] BUSCMD_BUS_RESET   = 4'hA;
  localparam logic [3:0] BUSCMD_SHUTDOWN    = 4'hB;
  localparam logic [3:0] BUSCMD_RESET       = 4'hF;

endpackage

// File: rtl/saturn_bus_prog_ram.sv
// Bus program buffer: synchronous write, asynchronous read, no reset
// (contents are only meaningful below the captured length).
module saturn_bus_prog_ram
  import saturn_bus_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 31
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [ENTRY_W-1:0] o_rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/saturn_bus_sequencer.sv
// Plays a captured bus program onto the Saturn nibble bus, one word per issue
// phase, then optionally streams read nibbles back to the control unit.
module saturn_bus_sequencer
  import saturn_bus_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int IDLE_ADDR   = 31,
  parameter int ISSUE_PHASE = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [3:0]        i_phases,
  input  logic              i_debug_cycle,
  input  logic [ADDR_W-1:0] i_program_address,
  input  logic [4:0]        i_program_data,
  input  logic              i_go,
  input  logic              i_no_read,
  output logic              o_bus_busy,
  output logic [3:0]        o_bus_data,
  output logic              o_bus_cmd,
  output logic              o_bus_strobe,
  input  logic [3:0]        i_bus_nibble,
  output logic [3:0]        o_nibble,
  output logic              o_nibble_valid,
  output logic              o_error,
  output logic [1:0]        o_dbg_state
);

  // o_bus_strobe and o_nibble_valid are single-cycle valid pulses qualifying
  // their data outputs; there is no ready, the consumer must take them.
  bus_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  len_q, len_d, ptr_q, ptr_d;
  logic [3:0]         data_q, data_d, nib_q, nib_d;
  logic               cmd_q, cmd_d, stb_q, stb_d, nv_q, nv_d;
  logic [ENTRY_W-1:0] entry;
  logic [ADDR_W-1:0]  addr_plus1, cap_len;
  logic               cap_req, capture, qual;

  assign cap_req    = i_program_address != ADDR_W'(IDLE_ADDR);
  assign capture    = cap_req && (state_q == S_IDLE || state_q == S_READ);
  assign qual       = i_phases[ISSUE_PHASE] && !i_debug_cycle;
  assign addr_plus1 = i_program_address + ADDR_W'(1);
  // Length as seen by a same-cycle go: the capture lands first.
  assign cap_len    = (capture && addr_plus1 > len_q) ? addr_plus1 : len_q;

  saturn_bus_prog_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (IDLE_ADDR)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (capture),
    .i_waddr (i_program_address),
    .i_wdata (i_program_data),
    .i_raddr (ptr_q),
    .o_rdata (entry)
  );

  always_comb begin
    state_d = state_q;
    len_d   = cap_len;
    ptr_d   = ptr_q;
    data_d  = data_q;
    cmd_d   = cmd_q;
    stb_d   = 1'b0;
    nib_d   = nib_q;
    nv_d    = 1'b0;
    case (state_q)
      S_IDLE, S_READ: begin
        if (!i_debug_cycle) begin
          if (i_go) begin
            if (cap_len != '0) begin
              state_d = S_RUN;
              ptr_d   = '0;
            end else begin
              state_d = S_ERROR;
            end
          end else if (state_q == S_READ) begin
            if (capture || i_no_read) begin
              state_d = S_IDLE;
            end else if (qual) begin
              nib_d = i_bus_nibble;
              nv_d  = 1'b1;
            end
          end
        end
      end
      S_RUN: begin
        if (!i_debug_cycle) begin
          if (cap_req || i_go) begin
            state_d = S_ERROR;
          end else if (qual) begin
            data_d = entry[3:0];
            cmd_d  = entry[CMD_BIT];
            stb_d  = 1'b1;
            ptr_d  = ptr_q + ADDR_W'(1);
            if (ptr_q == len_q - ADDR_W'(1)) begin
              len_d   = '0;
              state_d = i_no_read ? S_IDLE : S_READ;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      cmd_q   <= 1'b0;
      stb_q   <= 1'b0;
      nib_q   <= '0;
      nv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
      stb_q   <= stb_d;
      nib_q   <= nib_d;
      nv_q    <= nv_d;
    end
  end

  assign o_bus_busy     = state_q == S_RUN;
  assign o_error        = state_q == S_ERROR;
  assign o_bus_data     = data_q;
  assign o_bus_cmd      = cmd_q;
  assign o_bus_strobe   = stb_q;
  assign o_nibble       = nib_q;
  assign o_nibble_valid = nv_q;
  assign o_dbg_state    = state_q;

endmodule
